// File: rtl/axi2apb_wr.sv
// Write path of the AXI-to-APB bridge: takes one W beat per command, extracts the
// addressed 32-bit lane for the APB master and returns the B response after completion.
module axi2apb_wr #(
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        cmd_start_wr,
    input  logic                        cmd_err,
    input  logic [AXI_ID_WIDTH-1:0]     cmd_id,
    input  logic [APB_ADDR_WIDTH+3:0]   cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                        WLAST,
    input  logic                        WVALID,
    output logic                        WREADY,
    input  logic                        psel,
    input  logic                        penable,
    input  logic                        pwrite,
    input  logic                        pready,
    input  logic                        pslverr,
    output logic [31:0]                 pwdata,
    output logic [3:0]                  pstrb,
    output logic                        wdata_valid,
    output logic [AXI_ID_WIDTH-1:0]     BID,
    output logic [1:0]                  BRESP,
    output logic                        BVALID,
    input  logic                        BREADY,
    output logic                        finish_wr
);

    localparam int NLANES      = AXI_DATA_WIDTH / 32;
    localparam int EXTRA_LANES = $clog2(NLANES);
    localparam int LANE_W      = (EXTRA_LANES == 0) ? 1 : EXTRA_LANES;

    typedef enum logic [2:0] {IDLE, W_WAIT, W_DRAIN, APB_WAIT, B_RESP} state_t;

    state_t                    state_q, state_d;
    logic [AXI_ID_WIDTH-1:0]   cmd_id_q;
    logic                      cmd_err_q;
    logic [LANE_W-1:0]         lane_q, lane_in;
    logic                      burst_err_q;
    logic [31:0]               pwdata_q;
    logic [3:0]                pstrb_q;
    logic [AXI_ID_WIDTH-1:0]   bid_q;
    logic [1:0]                bresp_q;
    logic                      accept, w_hs, apb_done, enter_b;
    logic                      unused_addr;

    // Only the lane-select bits of the address matter on the write data path.
    generate
        if (EXTRA_LANES == 0) begin : g_one_lane
            assign lane_in = '0;
        end else begin : g_lanes
            assign lane_in = cmd_addr[2+EXTRA_LANES-1:2];
        end
    endgenerate
    assign unused_addr = ^cmd_addr;

    assign WREADY      = (state_q == W_WAIT) || (state_q == W_DRAIN);
    assign wdata_valid = (state_q == APB_WAIT);
    assign BVALID      = (state_q == B_RESP);
    assign finish_wr   = BVALID & BREADY;
    assign w_hs        = WVALID & WREADY;
    assign apb_done    = psel & penable & pwrite & pready;
    assign enter_b     = (state_d == B_RESP) && (state_q != B_RESP);
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign BID         = bid_q;
    assign BRESP       = bresp_q;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_start_wr) begin
                    accept  = 1'b1;
                    state_d = W_WAIT;
                end
            end
            W_WAIT: begin
                if (w_hs) begin
                    if (!WLAST)        state_d = W_DRAIN;
                    else if (cmd_err_q) state_d = B_RESP;
                    else               state_d = APB_WAIT;
                end
            end
            W_DRAIN: begin
                if (w_hs && WLAST) state_d = cmd_err_q ? B_RESP : APB_WAIT;
            end
            APB_WAIT: begin
                if (apb_done) state_d = B_RESP;
            end
            B_RESP: begin
                // Retiring cycle may also accept the next command with no bubble.
                if (BREADY) begin
                    if (cmd_start_wr) begin
                        accept  = 1'b1;
                        state_d = W_WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cmd_id_q    <= '0;
            cmd_err_q   <= 1'b0;
            lane_q      <= '0;
            burst_err_q <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            bid_q       <= '0;
            bresp_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cmd_id_q    <= cmd_id;
                cmd_err_q   <= cmd_err;
                lane_q      <= lane_in;
                burst_err_q <= 1'b0;
            end
            // Lane data comes from the first beat; drained beats are dropped.
            if (state_q == W_WAIT && w_hs) begin
                pwdata_q <= WDATA[32*lane_q +: 32];
                pstrb_q  <= WSTRB[4*lane_q +: 4];
                if (!WLAST) burst_err_q <= 1'b1;
            end
            if (enter_b) begin
                bid_q <= cmd_id_q;
                if (cmd_err_q)                          bresp_q <= 2'b10;
                else if (state_q == APB_WAIT && pslverr) bresp_q <= 2'b11;
                else if (burst_err_q)                   bresp_q <= 2'b10;
                else                                    bresp_q <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_axi2apb_wr.sv
// Directed bench for axi2apb_wr: B responses are scoreboarded, lane data and
// handshake timing checked with immediate assertions.
module tb_axi2apb_wr;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_start_wr = 1'b0, cmd_err = 1'b0;
    logic [5:0]  cmd_id = '0;
    logic [15:0] cmd_addr = '0;
    logic [63:0] WDATA = '0;
    logic [7:0]  WSTRB = '0;
    logic        WLAST = 1'b0, WVALID = 1'b0, WREADY;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, pready = 1'b0, pslverr = 1'b0;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        wdata_valid;
    logic [5:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID, BREADY = 1'b0, finish_wr;

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [5:0] id; logic [1:0] resp; } bexp_t;
    bexp_t sb[$];

    axi2apb_wr dut (
        .clk(clk), .rstn(rstn), .cmd_start_wr(cmd_start_wr), .cmd_err(cmd_err),
        .cmd_id(cmd_id), .cmd_addr(cmd_addr), .WDATA(WDATA), .WSTRB(WSTRB),
        .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .psel(psel), .penable(penable), .pwrite(pwrite), .pready(pready), .pslverr(pslverr),
        .pwdata(pwdata), .pstrb(pstrb), .wdata_valid(wdata_valid),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY), .finish_wr(finish_wr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_cmd(input logic [5:0] id, input logic [15:0] addr, input logic err);
        @(negedge clk);
        cmd_id = id; cmd_addr = addr; cmd_err = err; cmd_start_wr = 1'b1;
        @(negedge clk);
        cmd_start_wr = 1'b0;
        #1 chk("wready_after_cmd", WREADY, 1'b1);
    endtask

    // Drives one beat and returns after its handshake edge (inputs released at the next negedge).
    task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic last);
        int n = 0;
        WDATA = d; WSTRB = s; WLAST = last; WVALID = 1'b1;
        while (!WREADY && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("w_handshake_bound", WREADY, 1'b1);
        @(negedge clk);
        WVALID = 1'b0; WLAST = 1'b0;
        #1;
    endtask

    task automatic apb_complete(input logic err);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; pready = 1'b1; pslverr = err;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pready = 1'b0; pslverr = 1'b0;
        #1;
    endtask

    task automatic wait_b();
        bexp_t e;
        int n = 0;
        while (!BVALID && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("bvalid_bound", BVALID, 1'b1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 1'b0, 1'b1);
        end else begin
            e = sb.pop_front();
            chk("bid", BID, e.id);
            chk("bresp", BRESP, e.resp);
        end
        BREADY = 1'b1;
        #1 chk("finish_wr", finish_wr, 1'b1);
        @(negedge clk);
        BREADY = 1'b0;
        #1 chk("bvalid_drop", BVALID, 1'b0);
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_wready", WREADY, 1'b0);
        chk("rst_bvalid", BVALID, 1'b0);
        chk("rst_wdata_valid", wdata_valid, 1'b0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_pstrb", pstrb, 4'h0);
        chk("rst_bid", BID, 6'h0);
        chk("rst_bresp", BRESP, 2'b00);
        @(negedge clk); rstn = 1'b1;

        // Upper lane selected by addr bit 2
        sb.push_back('{id: 6'h05, resp: 2'b00});
        start_cmd(6'h05, 16'h0004, 1'b0);
        w_beat(64'h11112222_33334444, 8'hF0, 1'b1);
        chk("t1_wdata_valid", wdata_valid, 1'b1);
        chk("t1_pwdata", pwdata, 32'h11112222);
        chk("t1_pstrb", pstrb, 4'hF);
        chk("t1_wready_low", WREADY, 1'b0);
        apb_complete(1'b0);
        chk("t1_b_latency", BVALID, 1'b1);
        chk("t1_wdata_valid_clr", wdata_valid, 1'b0);
        wait_b();

        // Lower lane
        sb.push_back('{id: 6'h11, resp: 2'b00});
        start_cmd(6'h11, 16'h0000, 1'b0);
        w_beat(64'h11112222_33334444, 8'hF0, 1'b1);
        chk("t2_pwdata", pwdata, 32'h33334444);
        chk("t2_pstrb", pstrb, 4'h0);
        apb_complete(1'b0);
        wait_b();

        // Decode error: no APB access, response right after the beat
        sb.push_back('{id: 6'h22, resp: 2'b10});
        start_cmd(6'h22, 16'h0004, 1'b1);
        w_beat(64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b1);
        chk("t3_wdata_valid", wdata_valid, 1'b0);
        chk("t3_bvalid_next", BVALID, 1'b1);
        wait_b();

        // 3-beat burst: first beat kept, later beats drained, SLVERR-class response
        sb.push_back('{id: 6'h07, resp: 2'b10});
        start_cmd(6'h07, 16'h0004, 1'b0);
        w_beat(64'hAAAA0001_BBBB0001, 8'h3C, 1'b0);
        chk("t4_pwdata_b1", pwdata, 32'hAAAA0001);
        chk("t4_wready_drain", WREADY, 1'b1);
        w_beat(64'hAAAA0002_BBBB0002, 8'hFF, 1'b0);
        chk("t4_wdata_valid_mid", wdata_valid, 1'b0);
        w_beat(64'hAAAA0003_BBBB0003, 8'hFF, 1'b1);
        chk("t4_wdata_valid", wdata_valid, 1'b1);
        chk("t4_pwdata", pwdata, 32'hAAAA0001);
        chk("t4_pstrb", pstrb, 4'h3);
        apb_complete(1'b0);
        wait_b();

        // pslverr -> 11, BREADY held off, then back-to-back command
        sb.push_back('{id: 6'h2A, resp: 2'b11});
        start_cmd(6'h2A, 16'h0000, 1'b0);
        w_beat(64'h0, 8'h0F, 1'b1);
        apb_complete(1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_bvalid", BVALID, 1'b1);
            chk("t5_hold_bid", BID, 6'h2A);
            chk("t5_hold_bresp", BRESP, 2'b11);
            @(negedge clk); #1;
        end
        begin
            bexp_t e;
            e = sb.pop_front();
            chk("t5_bid", BID, e.id);
            chk("t5_bresp", BRESP, e.resp);
        end
        sb.push_back('{id: 6'h15, resp: 2'b00});
        BREADY = 1'b1;
        cmd_id = 6'h15; cmd_addr = 16'h0004; cmd_err = 1'b0; cmd_start_wr = 1'b1;
        #1 chk("t5_finish_wr", finish_wr, 1'b1);
        @(negedge clk);
        BREADY = 1'b0; cmd_start_wr = 1'b0;
        #1;
        chk("t5_b2b_wready", WREADY, 1'b1);
        chk("t5_b2b_bvalid", BVALID, 1'b0);
        w_beat(64'h5555AAAA_12345678, 8'hA0, 1'b1);
        chk("t5_b2b_pwdata", pwdata, 32'h5555AAAA);
        chk("t5_b2b_pstrb", pstrb, 4'hA);
        apb_complete(1'b0);
        wait_b();

        // Reset while waiting for APB; a later completion must not produce a response
        start_cmd(6'h3F, 16'h0000, 1'b0);
        w_beat(64'h0000_0000_CAFE_F00D, 8'h0F, 1'b1);
        chk("t6_wdata_valid", wdata_valid, 1'b1);
        #2 rstn = 1'b0;
        #1;
        chk("t6_rst_bvalid", BVALID, 1'b0);
        chk("t6_rst_wready", WREADY, 1'b0);
        chk("t6_rst_wdata_valid", wdata_valid, 1'b0);
        chk("t6_rst_pwdata", pwdata, 32'h0);
        @(negedge clk); rstn = 1'b1;
        #1 apb_complete(1'b0);
        chk("t6_late_apb_bvalid", BVALID, 1'b0);
        @(negedge clk); #1;
        chk("t6_late_apb_bvalid2", BVALID, 1'b0);
        chk("t6_idle_wready", WREADY, 1'b0);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
